mdu_unit: RTL
=============

Name: mdu_unit

Overview:
Multiply/divide unit for the E stage. It owns the HI and LO registers and executes MULT/MULTU/DIV/DIVU with a fixed, realistic latency. It services MTHI/MTLO/MFHI/MFLO. Its read data drives E_HI_LO into the E/M pipeline register. The hazard unit uses busy/start to stall younger HI/LO instructions; req cancels work from an instruction that an exception or interrupt is squashing.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  1  exception/interrupt request; the E-stage instruction is squashed this cycle
start  input  1  E-stage instruction is a valid MDU op this cycle
op  input  `MDU_OP_SIZE (4)  operation code (shared constants)
rs_data  input  32  forwarded rs operand
rt_data  input  32  forwarded rt operand
busy  output  1  a mult/div is in flight
hi_lo  output  32  MFHI -> HI, MFLO -> LO, otherwise 0 (combinational)
hi_out  output  32  current HI register
lo_out  output  32  current LO register

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, counter=0, pending result=0, busy=0, and therefore hi_lo=0.
- An op is accepted at a rising edge only when start=1, req=0 and busy=0. start while busy is a hazard-unit error: ignore it, with no state change.
- MULT/MULTU: the 64-bit product of rs*rt (signed or unsigned) is computed at acceptance and latched as the pending result. Counter loads MULT_CYCLES.
- DIV/DIVU: pending LO=quotient, HI=remainder. Signed division truncates toward zero and the remainder takes the dividend's sign. Counter loads DIV_CYCLES.
- Divide by zero: busy runs the full DIV_CYCLES, then HI/LO are left unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- busy = (counter != 0). It rises the cycle after acceptance.
- Each edge with counter!=0 decrements the counter. On the edge where it goes 1->0, HI/LO take the pending result and busy falls.
- Total latency: HI/LO are visible exactly N cycles after the accepting edge (N = MULT_CYCLES or DIV_CYCLES).
- MTHI/MTLO: write rs_data into HI/LO at the accepting edge (start=1, req=0, busy=0). No busy cycles.
- MFHI/MFLO: pure combinational reads; no state change. Accept them even when req=1, since a squashed read is harmless.
- req=1 with start=1: a write/mult/div op does not start, and nothing changes.
- req=1 while busy: the in-flight op belongs to an older, committed instruction. Let it complete normally.
- Async reset mid-operation: the in-flight op is abandoned and all state clears immediately.
- Undefined op codes with start=1: no-op.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: ops MADD/MADDU/MSUB/MSUBU are supported. {HI,LO} +/- product (signed/unsigned, 64-bit wrap), latency MULT_CYCLES. The accumulate operand is {HI,LO} as sampled at acceptance.
- Undefined: these op codes are treated as undefined no-ops and the accumulate logic is absent.

Decomposition:
- Shared macros header holds `MDU_OP_SIZE and the op codes: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
- One natural sub-module: mdu_arith, combinational. It computes the 64-bit product/quotient/remainder (and the accumulate result) from op, rs, rt and {HI,LO}.
- The sequencing counter and HI/LO stay in mdu_unit.

Test Plan:
1. Reset low mid-run: release reset, start MULT rs=3 rt=-2, drop reset at cycle 2 -> immediately busy=0, HI=0, LO=0; no later write.
2. MULT rs=0xFFFFFFFF rt=2 -> busy 1 for cycles 1..5. After the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands -> HI=1, LO=0xFFFFFFFE.
3. DIV rs=-7 rt=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7 rt=0 -> busy 10 cycles, HI/LO unchanged.
4. MTHI 0x1234 then MFHI -> hi_lo=0x1234 the next cycle. MTLO with req=1 -> LO unchanged.
5. MULT with req=1 -> busy stays 0, HI/LO unchanged. MULT accepted then req=1 at cycle 3 -> completes at cycle 5 with the correct product.
6. (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, MADDU rs=1 rt=1 -> after 5 cycles HI=1, LO=0. Without the macro the same stimulus leaves HI/LO unchanged.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg
//   Shared definitions for the multiply/divide unit: operation-code width
//   macro, op codes, and a decode helper that sorts an op code into the
//   kind of work it asks the unit to do.
//
//   Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU decode as
//   multiply-class ops when defined, as undefined no-ops otherwise).

`ifndef MDU_OP_SIZE
`define MDU_OP_SIZE 4
`endif

package mdu_unit_pkg;

  localparam int OP_W = `MDU_OP_SIZE;

  localparam logic [OP_W-1:0] OP_NONE  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MADD  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MADDU = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MSUB  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MSUBU = OP_W'(12);

  // What an accepted op does to the unit's state.
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,  // no state change (MFHI/MFLO, undefined codes)
    CLS_MUL  = 3'd1,  // multi-cycle, MULT_CYCLES
    CLS_DIV  = 3'd2,  // multi-cycle, DIV_CYCLES
    CLS_MTHI = 3'd3,  // single-edge HI write
    CLS_MTLO = 3'd4   // single-edge LO write
  } mdu_cls_e;

  function automatic mdu_cls_e op_class(input logic [OP_W-1:0] op);
    mdu_cls_e cls;
    cls = CLS_NONE;
    case (op)
      OP_MULT, OP_MULTU: cls = CLS_MUL;
      OP_DIV, OP_DIVU:   cls = CLS_DIV;
      OP_MTHI:           cls = CLS_MTHI;
      OP_MTLO:           cls = CLS_MTLO;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = CLS_MUL;
`endif
      default:           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith
//   Combinational datapath of the multiply/divide unit. Produces the 64-bit
//   {hi, lo} result for the op presented, using one shared 64-bit multiplier
//   and one shared 32-bit unsigned divider (signed division runs on
//   magnitudes and re-applies signs).
//
//   Optional feature macro: MDU_MADD_EN (adds the {hi,lo} +/- product path).
//
// Ports:
//   op      in   operation code
//   rs, rt  in   operands (rs = multiplicand / dividend)
//   hi, lo  in   current HI/LO (accumulate operand)
//   res_hi  out  HI part of the result (remainder for divides)
//   res_lo  out  LO part of the result (quotient for divides)
//   res_wr  out  result should be committed (0 for divide by zero / non-arith)

module mdu_arith
  import mdu_unit_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     rs,
  input  logic [31:0]     rt,
  input  logic [31:0]     hi,
  input  logic [31:0]     lo,
  output logic [31:0]     res_hi,
  output logic [31:0]     res_lo,
  output logic            res_wr
);

  logic        is_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] q_raw;
  logic [31:0] r_raw;
  logic [31:0] quo;
  logic [31:0] rem;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV) ||
                     (op == OP_MADD) || (op == OP_MSUB);

  // Low 64 bits of a 64x64 product of the extended operands equal the
  // exact 32x32 signed or unsigned product.
  assign mul_a = is_signed ? {{32{rs[31]}}, rs} : {32'b0, rs};
  assign mul_b = is_signed ? {{32{rt[31]}}, rt} : {32'b0, rt};
  assign prod  = mul_a * mul_b;

  assign abs_rs = rs[31] ? -rs : rs;
  assign abs_rt = rt[31] ? -rt : rt;
  assign div_a  = is_signed ? abs_rs : rs;
  // Divisor forced non-zero so the divider never sees 0; the result is
  // discarded through res_wr in that case.
  assign div_b  = (rt == 32'd0) ? 32'd1 : (is_signed ? abs_rt : rt);
  assign q_raw  = div_a / div_b;
  assign r_raw  = div_a % div_b;

  // Quotient truncates toward zero, remainder follows the dividend. For
  // 0x80000000 / -1 the magnitude quotient 0x80000000 negates to itself,
  // which is the required wrap result.
  assign quo = (is_signed && (rs[31] ^ rt[31])) ? -q_raw : q_raw;
  assign rem = (is_signed && rs[31]) ? -r_raw : r_raw;

`ifdef MDU_MADD_EN
  logic [63:0] acc_add;
  logic [63:0] acc_sub;
  assign acc_add = {hi, lo} + prod;
  assign acc_sub = {hi, lo} - prod;
`else
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: begin
        {res_hi, res_lo} = prod;
        res_wr = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi = rem;
        res_lo = quo;
        res_wr = (rt != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        {res_hi, res_lo} = acc_add;
        res_wr = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        {res_hi, res_lo} = acc_sub;
        res_wr = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit
//   E-stage multiply/divide unit. Owns HI/LO, runs MULT/MULTU/DIV/DIVU with a
//   fixed latency through a down-counter, services MTHI/MTLO writes and
//   MFHI/MFLO reads. The result is computed at acceptance, parked in a
//   pending register and committed on the edge where the counter reaches 0.
//
//   Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU, MULT latency).
//
// Parameters:
//   MULT_CYCLES  busy cycles for multiply-class ops (>=1)
//   DIV_CYCLES   busy cycles for divides (>=1)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   req      in   exception/interrupt squashes the E-stage instruction
//   start    in   E-stage instruction is a valid MDU op
//   op       in   operation code
//   rs_data  in   forwarded rs operand
//   rt_data  in   forwarded rt operand
//   busy     out  a mult/div is in flight
//   hi_lo    out  HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi_out   out  current HI
//   lo_out   out  current LO

module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    start,
  input  logic [`MDU_OP_SIZE-1:0] op,
  input  logic [31:0]             rs_data,
  input  logic [31:0]             rt_data,
  output logic                    busy,
  output logic [31:0]             hi_lo,
  output logic [31:0]             hi_out,
  output logic [31:0]             lo_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_wr;
  mdu_cls_e         cls;
  logic             accept;

  mdu_arith u_arith (
    .op     (op),
    .rs     (rs_data),
    .rt     (rt_data),
    .hi     (hi_reg),
    .lo     (lo_reg),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .res_wr (res_wr)
  );

  assign cls    = op_class(op);
  assign busy   = (cnt != '0);
  // A squashed instruction must not start or write anything; reads need no
  // gating since they never change state.
  assign accept = start && !req && !busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      // An in-flight op always belongs to a committed instruction, so req
      // does not cancel it.
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1) && pend_wr) begin
        hi_reg <= pend_hi;
        lo_reg <= pend_lo;
      end
    end else if (accept) begin
      case (cls)
        CLS_MUL: begin
          cnt     <= CNT_W'(MULT_CYCLES);
          pend_hi <= res_hi;
          pend_lo <= res_lo;
          pend_wr <= res_wr;
        end
        CLS_DIV: begin
          cnt     <= CNT_W'(DIV_CYCLES);
          pend_hi <= res_hi;
          pend_lo <= res_lo;
          pend_wr <= res_wr;
        end
        CLS_MTHI: hi_reg <= rs_data;
        CLS_MTLO: lo_reg <= rs_data;
        default: ;
      endcase
    end
  end

  assign hi_lo  = (op == OP_MFHI) ? hi_reg :
                  (op == OP_MFLO) ? lo_reg : 32'd0;
  assign hi_out = hi_reg;
  assign lo_out = lo_reg;

endmodule
